// File: rtl/mac_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_arbiter_if
//  Description : Bundle between the four requesters / shared MAC register and
//                the round-robin MAC arbiter. The master side is the
//                environment (requesters plus MAC); the slave side is the
//                arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_arbiter_if #(
    parameter int REG_IN  = 7,
    parameter int REG_OUT = 15
);
    logic               en;
    logic [3:0]         req;
    logic [REG_IN:0]    a0, a1, a2, a3;
    logic [REG_IN:0]    b0, b1, b2, b3;
    logic [REG_IN:0]    c0, c1, c2, c3;
    logic [3:0]         gnt;
    logic [REG_IN:0]    mac_a, mac_b, mac_c;
    logic [REG_OUT:0]   mac_result;
    logic               res_valid;
    logic [1:0]         res_id;
    logic [REG_OUT:0]   res_data;
    logic               idle;

    modport master (
        output en, req, a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3, mac_result,
        input  gnt, mac_a, mac_b, mac_c, res_valid, res_id, res_data, idle
    );

    modport slave (
        input  en, req, a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3, mac_result,
        output gnt, mac_a, mac_b, mac_c, res_valid, res_id, res_data, idle
    );
endinterface
`default_nettype wire

// File: rtl/mac_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mac_arbiter
//  Description : Round-robin arbiter sharing one registered MAC between four
//                requesters. One grant per cycle in RUN, operands registered
//                at the grant edge, result returned two cycles after the
//                grant tagged with the owning requester index.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_arbiter #(
    parameter int REG_IN  = 7,
    parameter int REG_OUT = 15,
    parameter int N_REQ   = 4
) (
    input wire          clk,
    input wire          reset,
    mac_arbiter_if.slave bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [1:0]         r_ptr;
    logic [1:0]         w_idx;
    logic [3:0]         w_gnt;
    logic               w_gnt_any;
    logic [1:0]         w_gnt_id;

    logic [REG_IN:0]    w_op_a, w_op_b, w_op_c;
    logic [REG_IN:0]    r_mac_a, r_mac_b, r_mac_c;

    logic               r_v1, r_v2;
    logic [1:0]         r_id1, r_id2;
    logic [REG_OUT:0]   w_res_data;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and round-robin grant; search begins just after the last winner
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 4'b0000;
        w_gnt_any   = 1'b0;
        w_gnt_id    = r_ptr;
        w_idx       = r_ptr;
        case (r_state)
            c_IDLE: begin
                if (bus.en) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (!bus.en) begin
                    w_state_nxt = c_DRAIN;
                end
                for (int i = 1; i <= N_REQ; i++) begin
                    w_idx = r_ptr + 2'(i);
                    if (!w_gnt_any && bus.req[w_idx]) begin
                        w_gnt_any = 1'b1;
                        w_gnt_id  = w_idx;
                    end
                end
                if (w_gnt_any) begin
                    w_gnt[w_gnt_id] = 1'b1;
                end
            end
            c_DRAIN: begin
                // A fresh enable wins over finishing the drain
                if (bus.en) begin
                    w_state_nxt = c_RUN;
                end else if (!r_v1 && !r_v2) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Operand mux for the requester currently being granted
    always_comb begin
        w_op_a = bus.a0;
        w_op_b = bus.b0;
        w_op_c = bus.c0;
        case (w_gnt_id)
            2'd1: begin
                w_op_a = bus.a1;
                w_op_b = bus.b1;
                w_op_c = bus.c1;
            end
            2'd2: begin
                w_op_a = bus.a2;
                w_op_b = bus.b2;
                w_op_c = bus.c2;
            end
            2'd3: begin
                w_op_a = bus.a3;
                w_op_b = bus.b3;
                w_op_c = bus.c3;
            end
            default: begin
            end
        endcase
    end

    // Round-robin pointer and MAC operand registers, updated only on a grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr   <= 2'd3;
            r_mac_a <= '0;
            r_mac_b <= '0;
            r_mac_c <= '0;
        end else if (w_gnt_any) begin
            r_ptr   <= w_gnt_id;
            r_mac_a <= w_op_a;
            r_mac_b <= w_op_b;
            r_mac_c <= w_op_c;
        end
    end

    // Two-stage valid/id pipeline matching operand register plus MAC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_id1 <= 2'd0;
            r_id2 <= 2'd0;
        end else begin
            r_v1  <= w_gnt_any;
            r_v2  <= r_v1;
            if (w_gnt_any) begin
                r_id1 <= w_gnt_id;
            end
            r_id2 <= r_id1;
        end
    end

    assign w_res_data    = bus.mac_result;

    assign bus.gnt       = w_gnt;
    assign bus.mac_a     = r_mac_a;
    assign bus.mac_b     = r_mac_b;
    assign bus.mac_c     = r_mac_c;
    assign bus.res_valid = r_v2;
    assign bus.res_id    = r_id2;
    assign bus.res_data  = w_res_data;
    assign bus.idle      = (r_state == c_IDLE) && !r_v1 && !r_v2;

endmodule
`default_nettype wire

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameter REG_IN, default 7: MSB index of each operand; operand width is REG_IN+1.
REQ-002 Parameter REG_OUT, default 15: MSB index of the result; result width is REG_OUT+1.
REQ-003 Parameter N_REQ, default 4, fixed at 4: number of requesters; id width is 2.
REQ-004 clk  in  1: single clock; all state changes on the rising edge.
REQ-005 reset  in  1: asynchronous, active-high reset.
REQ-006 en  in  1: 1 allows new grants; 0 stops granting and drains the pipe.
REQ-007 req  in  4: per-requester request level, held until granted.
REQ-008 a0..a3, b0..b3, c0..c3  in  REG_IN+1 each: per-requester operands, stable while the matching req is high.
REQ-009 gnt  out  4: one-hot grant pulse, at most one bit high per cycle.
REQ-010 mac_a, mac_b, mac_c  out  REG_IN+1 each: registered operands to the shared MAC register.
REQ-011 mac_result  in  REG_OUT+1: shared MAC output, equal to mac_a*mac_b+mac_c one clock after the operands are presented.
REQ-012 res_valid  out  1: result strobe.
REQ-013 res_id  out  2: requester index that owns the current result.
REQ-014 res_data  out  REG_OUT+1: result data, equal to mac_result.
REQ-015 idle  out  1: high when the state is IDLE and no operation is in flight.

Function
REQ-016 The FSM SHALL have three states:
- IDLE: no grants.
- RUN: at most one grant per cycle.
- DRAIN: no grants; waits for in-flight results.
REQ-017 Transitions SHALL be:
- IDLE->RUN when en=1.
- RUN->DRAIN when en=0.
- DRAIN->IDLE when the pipe is empty.
- DRAIN->RUN when en=1 (en has priority over draining).
REQ-018 In RUN with any req bit high, the block SHALL grant exactly one requester per cycle using round-robin arbitration.
- Search starts at index ptr+1 (mod 4) and stops at the first requester with req high.
- After a grant to requester k, ptr SHALL become k.
- If no req bit is high, ptr SHALL hold.
REQ-019 gnt SHALL be combinational from the state, req and ptr.
- A requester SHALL treat gnt[k]=1 at a rising edge as acceptance.
- A requester MAY drop req or present new operands in the next cycle.
REQ-020 At a grant edge, mac_a, mac_b and mac_c SHALL load the granted requester's operands.
- Otherwise they SHALL hold their values.
REQ-021 Latency SHALL be fixed:
- A grant in cycle T yields res_valid=1 in cycle T+2.
- In that cycle, res_id is the granted index and res_data is mac_result.
REQ-022 The valid/id pipeline SHALL be two stages deep.
- Back-to-back grants SHALL produce back-to-back results in grant order.
- Sustained throughput is one result per cycle.
REQ-023 The block SHALL apply no backpressure on results; the consumer always accepts.
REQ-024 The result SHALL be mac_result unmodified.
- Arithmetic overflow is the MAC's modulo-2^(REG_OUT+1) behaviour.
- The block SHALL NOT saturate.
REQ-025 When en falls mid-burst, operations already granted SHALL complete and deliver their results.
REQ-026 A req that rises in a cycle where en=0 SHALL wait and SHALL NOT be granted until RUN.
REQ-027 idle SHALL be 1 only in IDLE with both pipeline valid stages clear.

Reset
REQ-028 Asserting reset SHALL immediately force:
- state to IDLE, ptr to 3 (so requester 0 has first priority), gnt to 0;
- both pipeline valid stages to 0, res_valid to 0, res_id to 0;
- mac_a, mac_b and mac_c to 0.
REQ-029 Reset asserted mid-operation SHALL discard in-flight results, and no res_valid SHALL follow reset.
REQ-030 On the first rising edge after reset release with en=1, the state SHALL enter RUN, and grants SHALL begin the following cycle.
REQ-031 idle SHALL read 1 during reset and after release until RUN is entered.

Verification
REQ-032 Single op: req=0001, a0=3, b0=4, c0=5, en=1 -> gnt=0001 for one cycle; two cycles later res_valid=1, res_id=0, res_data=17.
REQ-033 All four requesting continuously from reset -> grants in order 0,1,2,3,0 on consecutive cycles; results in the same order, one per cycle.
REQ-034 Fairness: req=1001 continuously -> grants alternate 0,3,0,3; requesters 1 and 2 are never granted.
REQ-035 Drain: en drops one cycle after two grants -> no further gnt; both results arrive; then idle=1.
REQ-036 Overflow: REG_IN=7, REG_OUT=15, a=b=255, c=255 -> res_data=65280.
REQ-037 Reset: reset pulsed in the cycle after a grant -> no res_valid appears; gnt=0000 and idle=1 during reset.
